// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: state encoding, timing defaults
// and the recovery rule for unused state codes.
package keypad_scan_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'b00,
      DEBOUNCE = 2'b01,
      PRESSED  = 2'b10
   } scan_state_t;

   localparam int DEF_ROWS            = 4;
   localparam int DEF_COLS            = 4;
   localparam int DEF_SETTLE_CYCLES   = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   // Any code outside the three legal states falls back to SCAN, so an upset
   // state register resumes scanning instead of locking up.
   function automatic scan_state_t legal_state(input scan_state_t s);
      case (s)
         SCAN, DEBOUNCE, PRESSED: return s;
         default:                 return SCAN;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side bundle of the keypad scanner: row inputs, column drive and the
// decoded key report. The scanner owns the master side.
interface keypad_scan_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   logic [ROWS-1:0]  row_n;
   logic [COLS-1:0]  col_n;
   logic             key_valid;
   logic [RW+CW-1:0] key_code;
   logic             key_down;
   logic [CW-1:0]    scan_col;

   modport master (
      input  row_n,
      output col_n, key_valid, key_code, key_down, scan_col
   );

   modport slave (
      output row_n,
      input  col_n, key_valid, key_code, key_down, scan_col
   );
endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchroniser for a bus of independent slow inputs. Both stages
// reset to all ones, which is the idle level of active-low keypad rows.
module sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   // Two register stages, so metastability settles before q is used.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make both stages sample old values on
      // the same edge; blocking ones would collapse the chain into one flop.
      if (rst) begin
         meta_q <= '1;
         q      <= '1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// Active-low matrix keypad scanner. Walks one low column across the pad,
// debounces a press on the synchronised rows, reports it once as a key_valid
// pulse with {row, col}, then waits for a debounced release before scanning on.
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int ROWS            = DEF_ROWS,
   parameter int COLS            = DEF_COLS,
   parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);

   localparam int RW      = $clog2(ROWS);
   localparam int CW      = $clog2(COLS);
   localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]    COL_LAST      = CW'(COLS - 1);

   logic [ROWS-1:0]  row_s;

   scan_state_t      state_q,     state_nxt;
   logic [CNT_W-1:0] cnt_q,       cnt_nxt;
   logic [CW-1:0]    col_q,       col_nxt;
   logic [ROWS-1:0]  cand_q,      cand_nxt;
   logic [COLS-1:0]  col_n_q;
   logic             key_valid_q, key_valid_nxt;
   logic [RW+CW-1:0] key_code_q,  key_code_nxt;
   logic             key_down_q,  key_down_nxt;

   logic             rows_idle;
   logic [RW-1:0]    low_row;
   logic [CW-1:0]    col_adv;

   sync2 #(.WIDTH(ROWS)) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (kp.row_n),
      .q   (row_s)
   );

   assign rows_idle = &row_s;
   assign col_adv   = (col_q == COL_LAST) ? '0 : col_q + CW'(1);

   // Lowest-index low row of the candidate pattern; row 0 wins ties.
   always_comb begin
      low_row = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!cand_q[r]) low_row = RW'(r);
      end
   end

   // Next-state and next-output logic for the scan/debounce/hold sequence.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      state_nxt     = state_q;
      cnt_nxt       = cnt_q;
      col_nxt       = col_q;
      cand_nxt      = cand_q;
      key_valid_nxt = 1'b0;
      key_code_nxt  = key_code_q;
      key_down_nxt  = key_down_q;

      case (legal_state(state_q))
         SCAN: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_nxt = '0;
               if (rows_idle) begin
                  col_nxt = col_adv;
               end else begin
                  cand_nxt  = row_s;
                  state_nxt = DEBOUNCE;
               end
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         DEBOUNCE: begin
            if (row_s != cand_q) begin
               // Bounce: rescan this same column from the start.
               state_nxt = SCAN;
               cnt_nxt   = '0;
            end else if (cnt_q == DEBOUNCE_LAST) begin
               state_nxt     = PRESSED;
               cnt_nxt       = '0;
               key_valid_nxt = 1'b1;
               key_down_nxt  = 1'b1;
               key_code_nxt  = {low_row, col_q};
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         PRESSED: begin
            if (!rows_idle) begin
               cnt_nxt = '0;
            end else if (cnt_q == DEBOUNCE_LAST) begin
               state_nxt    = SCAN;
               cnt_nxt      = '0;
               key_down_nxt = 1'b0;
               col_nxt      = col_adv;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter, candidate and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         cnt_q       <= '0;
         col_q       <= '0;
         cand_q      <= '1;
         col_n_q     <= '1;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         key_down_q  <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cnt_q       <= cnt_nxt;
         col_q       <= col_nxt;
         cand_q      <= cand_nxt;
         col_n_q     <= ~(COLS'(1) << col_nxt);
         key_valid_q <= key_valid_nxt;
         key_code_q  <= key_code_nxt;
         key_down_q  <= key_down_nxt;
      end
   end

   assign kp.col_n     = col_n_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_down  = key_down_q;
   assign kp.scan_col  = col_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan. A physical pad model pulls a row low
// when a pressed key sits on the currently driven column; expectations come
// from key-level rules (one report per press, lowest row wins, release needed).
module tb_keypad_scan;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DEB  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [ROWS*COLS-1:0] press = '0;

   int checks   = 0;
   int failures = 0;
   int kv_count = 0;
   bit kv_prev  = 1'b0;
   bit kv_double = 1'b0;

   keypad_scan_if #(.ROWS(ROWS), .COLS(COLS)) kp_if ();

   keypad_scan #(
      .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp_if.master)
   );

   always #5 clk = ~clk;

   // Pad model: a row reads low when any pressed key on it has its column driven low.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         kp_if.row_n[r] = 1'b1;
         for (int c = 0; c < COLS; c++) begin
            if (press[r*COLS+c] && !kp_if.col_n[c]) kp_if.row_n[r] = 1'b0;
         end
      end
   end

   // Count key_valid pulses and flag any pulse wider than one clock.
   always @(negedge clk) begin
      if (kp_if.key_valid === 1'b1) begin
         kv_count <= kv_count + 1;
         if (kv_prev) kv_double <= 1'b1;
      end
      kv_prev <= (kp_if.key_valid === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int key_bit(input int r, input int c);
      return r * COLS + c;
   endfunction

   task automatic wait_valid(input int bound, output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (kp_if.key_valid !== 1'b1 && waited < bound);
   endtask

   task automatic wait_release(input int bound, output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (kp_if.key_down !== 1'b0 && waited < bound);
   endtask

   initial begin
      logic [COLS-1:0] vals[$];
      int              runs[$];
      logic [COLS-1:0] exp_col;
      logic [COLS-1:0] prev_col;
      logic [3:0]      exp_code;
      int              base;
      int              w;
      int              found;

      // ---- Reset state and free-running scan ----
      rst = 1'b1;
      repeat (3) tick();
      check("rst_col_n", kp_if.col_n, 4'b1111);
      check("rst_key_valid", kp_if.key_valid, 1'b0);
      check("rst_key_code", kp_if.key_code, 4'b0000);
      check("rst_key_down", kp_if.key_down, 1'b0);
      check("rst_scan_col", kp_if.scan_col, 2'd0);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         tick();
         if (vals.size() == 0 || vals[$] != kp_if.col_n) begin
            vals.push_back(kp_if.col_n);
            runs.push_back(1);
         end else begin
            runs[$] = runs[$] + 1;
         end
      end
      check("scan_len", vals.size() >= 5, 1'b1);
      if (vals.size() >= 5) begin
         for (int k = 0; k < 5; k++) begin
            exp_col = ~(4'b0001 << (k % COLS));
            check($sformatf("scan_col_n[%0d]", k), vals[k], exp_col);
         end
         for (int k = 1; k < 4; k++) check($sformatf("scan_hold[%0d]", k), runs[k], 4);
      end
      check("scan_no_valid", kv_count, 0);

      // ---- Key r1,c2 held ----
      base = kv_count;
      press = '0;
      press[key_bit(1, 2)] = 1'b1;
      wait_valid(80, w);
      check("r1c2_valid", kp_if.key_valid, 1'b1);
      check("r1c2_code", kp_if.key_code, 4'b0110);
      check("r1c2_down", kp_if.key_down, 1'b1);
      check("r1c2_col_n", kp_if.col_n, 4'b1011);
      tick();
      check("r1c2_pulse_width", kp_if.key_valid, 1'b0);
      repeat (30) tick();
      check("r1c2_no_repeat", kv_count - base, 1);
      check("r1c2_col_hold", kp_if.col_n, 4'b1011);
      check("r1c2_down_hold", kp_if.key_down, 1'b1);

      // ---- Short release with re-press, then full release ----
      press = '0;
      repeat (15) tick();
      press[key_bit(1, 2)] = 1'b1;
      tick();
      check("repress_down", kp_if.key_down, 1'b1);
      press = '0;
      wait_release(40, w);
      check("release_down", kp_if.key_down, 1'b0);
      check("release_min_wait", w >= DEB, 1'b1);
      check("release_col_n", kp_if.col_n, 4'b0111);
      check("release_no_valid", kv_count - base, 1);

      // ---- Bounce during debounce ----
      found = 0;
      prev_col = kp_if.col_n;
      for (int i = 0; i < 40 && found == 0; i++) begin
         tick();
         if (kp_if.col_n == 4'b1011 && prev_col != 4'b1011) found = 1;
         prev_col = kp_if.col_n;
      end
      check("bounce_col_found", found, 1);
      base = kv_count;
      press[key_bit(1, 2)] = 1'b1;
      repeat (10) tick();
      press = '0;
      tick();
      check("bounce_early_none", kv_count - base, 0);
      press[key_bit(1, 2)] = 1'b1;
      wait_valid(80, w);
      check("bounce_valid", kp_if.key_valid, 1'b1);
      check("bounce_stable_wait", w >= DEB, 1'b1);
      check("bounce_code", kp_if.key_code, 4'b0110);
      press = '0;
      wait_release(40, w);
      check("bounce_release", kp_if.key_down, 1'b0);
      check("bounce_single", kv_count - base, 1);

      // ---- Two rows on column 0: row 0 wins ----
      base = kv_count;
      press[key_bit(0, 0)] = 1'b1;
      press[key_bit(1, 0)] = 1'b1;
      wait_valid(80, w);
      check("multi_valid", kp_if.key_valid, 1'b1);
      check("multi_code", kp_if.key_code, 4'b0000);
      repeat (10) tick();
      press = '0;
      wait_release(40, w);
      check("multi_release", kp_if.key_down, 1'b0);
      check("multi_single", kv_count - base, 1);

      // ---- Reset while pressed, key still held afterwards ----
      press[key_bit(2, 1)] = 1'b1;
      wait_valid(80, w);
      check("rsthold_valid", kp_if.key_valid, 1'b1);
      check("rsthold_code", kp_if.key_code, 4'b1001);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check("rsthold_col_n", kp_if.col_n, 4'b1111);
      check("rsthold_down", kp_if.key_down, 1'b0);
      check("rsthold_code_clr", kp_if.key_code, 4'b0000);
      check("rsthold_kv", kp_if.key_valid, 1'b0);
      rst = 1'b0;
      base = kv_count;
      wait_valid(80, w);
      check("rsthold_redetect", kp_if.key_valid, 1'b1);
      check("rsthold_recode", kp_if.key_code, 4'b1001);
      repeat (20) tick();
      check("rsthold_single", kv_count - base, 1);
      press = '0;
      wait_release(40, w);
      check("rsthold_release", kp_if.key_down, 1'b0);

      // ---- Randomised presses with short glitches in between ----
      for (int it = 0; it < 12; it++) begin
         int col;
         int rmask;
         int low;

         base = kv_count;
         press = '0;
         press[key_bit($urandom_range(ROWS - 1, 0), $urandom_range(COLS - 1, 0))] = 1'b1;
         repeat ($urandom_range(8, 1)) tick();
         press = '0;
         repeat (4) tick();
         check($sformatf("rnd%0d_glitch", it), kv_count - base, 0);

         col   = $urandom_range(COLS - 1, 0);
         rmask = $urandom_range(15, 1);
         low   = -1;
         for (int r = 0; r < ROWS; r++) begin
            if (rmask[r]) begin
               press[key_bit(r, col)] = 1'b1;
               if (low < 0) low = r;
            end
         end
         exp_code = {2'(low), 2'(col)};
         base = kv_count;
         wait_valid(80, w);
         check($sformatf("rnd%0d_valid", it), kp_if.key_valid, 1'b1);
         check($sformatf("rnd%0d_code", it), kp_if.key_code, exp_code);
         repeat ($urandom_range(20, 1)) tick();
         check($sformatf("rnd%0d_single", it), kv_count - base, 1);
         check($sformatf("rnd%0d_down", it), kp_if.key_down, 1'b1);
         press = '0;
         wait_release(40, w);
         check($sformatf("rnd%0d_release", it), kp_if.key_down, 1'b0);
         repeat ($urandom_range(10, 0)) tick();
      end

      check("no_wide_pulse", kv_double, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Active-low matrix keypad scanner. It is the driving end of the row/column button interface: it walks a single low column across the pad and reads the active-low rows back.
- A press is debounced, then reported as a one-cycle `key_valid` pulse carrying a row/column key code. A debounced release is required before scanning resumes.
- Sits between the board keypad pins and the input-decode logic. It replaces free-running per-button edge detection with one scanned source.

Parameters:
- ROWS, 4, number of row inputs.
- COLS, 4, number of column outputs.
- SETTLE_CYCLES, 4, clocks a column is held low before the rows are sampled (must be ≥1).
- DEBOUNCE_CYCLES, 16, consecutive stable clocks required to accept a press or a release (must be ≥1).
- RW, $clog2(ROWS), row-index width (derived; not to be overridden).
- CW, $clog2(COLS), column-index width (derived; not to be overridden).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- row_n  in  ROWS  keypad rows, active-low, asynchronous to clk.
- col_n  out  COLS  column drive, active-low, at most one bit low.
- key_valid  out  1  one-cycle pulse: debounced press accepted.
- key_code  out  RW+CW  {row_idx, col_idx} of the last accepted key; holds until the next press.
- key_down  out  1  high from the accepted press until the debounced release.
- scan_col  out  CW  column index currently driven (debug).

Behaviour:
- Reset (rst=1 at posedge):
  - col_n=all 1s, key_valid=0, key_code=0, key_down=0, scan_col=0.
  - State=SCAN, counter=0, row synchroniser=all 1s.
  - Reset mid-press or mid-debounce discards all progress. No `key_valid` is issued for a press that was in progress.
- row_n passes through a 2-flop synchroniser (row_s) that resets to all 1s. All decisions use row_s only.
- col_n, key_valid, key_code, key_down and scan_col are all registered. col_n = ~(1<<scan_col) whenever not in reset.
- State SCAN:
  - Drive column scan_col; counter counts 0..SETTLE_CYCLES-1.
  - At counter==SETTLE_CYCLES-1, sample row_s.
  - If all rows are high: scan_col wraps COLS-1 -> 0, otherwise increments; counter=0.
  - If any row is low: latch the pattern as cand, go to DEBOUNCE, counter=0.
- State DEBOUNCE:
  - Hold the column.
  - While row_s==cand, counter increments.
  - Any row_s != cand: return to SCAN at the same column, counter=0, no output.
  - At counter==DEBOUNCE_CYCLES-1 with row_s==cand: go to PRESSED.
  - On that transition edge: key_valid=1 for exactly one cycle, key_down=1, key_code={lowest-index low row in cand, scan_col}.
  - Multiple rows low in one column resolve to the lowest row index. Other columns are not examined while a key is held.
- State PRESSED:
  - Hold the column.
  - Counter counts consecutive cycles with row_s all 1s; any low row resets the counter to 0.
  - At counter==DEBOUNCE_CYCLES-1: key_down=0, advance scan_col (with wrap), go to SCAN, counter=0.
  - No repeat `key_valid` is ever issued while held.
- Latency:
  - Press appearing on row_n while its column is driven → key_valid 2 (sync) + remaining settle cycles + DEBOUNCE_CYCLES clocks later.
  - Worst case adds one full scan: COLS*SETTLE_CYCLES.
- key_valid and key_down never rise in the same cycle except at press acceptance, where they rise together.

Decomposition:
- Shared package holds:
  - the state encoding SCAN=2'b00, DEBOUNCE=2'b01, PRESSED=2'b10;
  - a default→SCAN recovery rule;
  - the default timing constants.
- Sub-module `sync2` (parameterised width, reset value all 1s) for row_n.
- Lowest-set-bit row encode stays inline.

Test Plan:
- Reset, no keys → col_n cycles 1110,1101,1011,0111,1110 with each value held 4 clocks; key_valid never 1.
- Hold row_n=1101 only while col_n=1011 (key r1,c2) ≥30 clocks → key_valid=1 for exactly 1 clock; key_code=4'b0110; key_down=1; col_n stays 1011.
- From held r1,c2: release for 16 clocks → key_down=0, next col_n=0111. Release for 15 clocks then 1-clock re-press → key_down stays 1, no new key_valid.
- Bounce during DEBOUNCE: row_n low 10 clocks, high 1, low 20 → press accepted only 16 stable clocks after the last bounce; single key_valid.
- row_n=1100 on col 0 → key_code=4'b0000 (row 0 wins); single key_valid.
- Assert rst during PRESSED → next clock col_n=1111, key_down=0, key_code=0. With the key still held after rst releases, the scan re-detects it and issues one fresh key_valid.
